piso_serializer: RTL

Downstream stage of the 4-bit parallel-in/parallel-out register. Accepts a parallel word through a valid/ready handshake and shifts it out one bit per transfer on a serial stream that has its own valid/ready backpressure. Gives the datapath a word-to-bitstream conversion with no gaps between back-to-back words.

---
 rtl/piso_serializer_pkg.sv | 14 +
 rtl/piso_bit_counter.sv | 30 +++
 rtl/piso_serializer.sv | 82 ++++++++
 3 files changed

// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the serial output blocks:
// state encoding and the bit-count width helper.
package piso_serializer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    function automatic int cnt_width(input int width);
        return (width < 3) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Bit counter for the serializer: clear, enable and a
// terminal flag at WIDTH-1; never wraps on its own.
module piso_bit_counter
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH = 4,
    localparam int CW = cnt_width(WIDTH)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    logic [CW-1:0] count;

    assign terminal = (count == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !terminal) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out converter with valid/ready on
// both sides and zero-bubble back-to-back words.
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             serial_out,
    output logic             serial_valid,
    input  logic             serial_ready,
    output logic             serial_last,
    output logic             word_done
);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] sreg;
    logic             terminal;
    logic             xfer;
    logic             accept;
    logic             done;

    assign serial_valid = (state == ST_SHIFT);
    assign serial_last  = serial_valid && terminal;
    assign serial_out   = (MSB_FIRST != 0) ? sreg[WIDTH-1]
                                           : sreg[0];
    assign xfer         = serial_valid && serial_ready;
    // Ready reaches back through serial_ready so a new word
    // can load on the same edge the last bit leaves.
    assign load_ready   = reset &&
                          (!serial_valid || (serial_last && serial_ready));
    assign accept       = load_valid && load_ready;
    assign word_done    = done;

    piso_bit_counter #(
        .WIDTH(WIDTH)
    ) u_cnt (
        .clk     (clk),
        .reset   (reset),
        .clear   (accept || (xfer && serial_last)),
        .enable  (xfer && !serial_last),
        .terminal(terminal)
    );

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (accept) state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (xfer && serial_last)
                    state_next = accept ? ST_SHIFT : ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            sreg  <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            done  <= xfer && serial_last;
            if (accept) begin
                sreg <= parallel_in;
            end else if (xfer) begin
                sreg <= (MSB_FIRST != 0)
                      ? {sreg[WIDTH-2:0], 1'b0}
                      : {1'b0, sreg[WIDTH-1:1]};
            end
        end
    end

endmodule
